// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single memory command port
module mem_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,

    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic              mem_cmd_valid,
    output logic              mem_cmd_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_cmd_ready,
    input  logic              mem_rdata_valid,
    input  logic              mem_wack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              grant,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Counter is 8 bits wide; the legal TIMEOUT range keeps it from wrapping.
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              winner;
    logic [7:0]        cnt_inc;
    logic              timeout_hit;
    logic              rsp_match;

    // Winner selection: a lone requester wins; on a tie the port that did not go last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = req1_valid;
        end
    end

    // Timeout detection and response qualification against the latched direction.
    always_comb begin
        cnt_inc     = cnt_q + 8'd1;
        timeout_hit = (cnt_inc >= TIMEOUT_C);
        rsp_match   = cmd_write_q ? mem_wack : mem_rdata_valid;
    end

    // Next-state logic for the transaction FSM and its latched fields.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cmd_write_d  = cmd_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d     = winner;
                    cmd_write_d = winner ? req1_write : req0_write;
                    addr_d      = winner ? req1_addr  : req0_addr;
                    wdata_d     = winner ? req1_wdata : req0_wdata;
                    cnt_d       = 8'd0;
                    state_d     = S_ISSUE;
                end
            end

            S_ISSUE: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (mem_cmd_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_inc;
                // A real response arriving on the timeout cycle still counts as success.
                if (rsp_match) begin
                    err_d = 1'b0;
                    if (!cmd_write_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                last_grant_d = grant_q;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 8'd0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cmd_write_q  <= cmd_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Output decode: strobes follow the registered state, fields come from the latches.
    always_comb begin
        mem_cmd_valid = (state_q == S_ISSUE);
        mem_cmd_write = cmd_write_q;
        mem_addr      = addr_q;
        mem_wdata     = wdata_q;
        req0_done     = (state_q == S_DONE) && !grant_q;
        req1_done     = (state_q == S_DONE) &&  grant_q;
        rsp_rdata     = rdata_q;
        rsp_err       = err_q;
        grant         = grant_q;
        busy          = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [24:0] req0_addr, req1_addr;
    logic [15:0] req0_wdata, req1_wdata;
    logic        mem_cmd_ready, mem_rdata_valid, mem_wack;
    logic [15:0] mem_rdata;

    logic        req0_done, req1_done, rsp_err, mem_cmd_valid, mem_cmd_write, grant, busy;
    logic [15:0] rsp_rdata, mem_wdata;
    logic [24:0] mem_addr;

    logic        t_req0_done, t_req1_done, t_rsp_err, t_mem_cmd_valid, t_mem_cmd_write, t_grant, t_busy;
    logic [15:0] t_rsp_rdata, t_mem_wdata;
    logic [24:0] t_mem_addr;

    int total;
    int bad;

    mem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_write(mem_cmd_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cmd_ready(mem_cmd_ready),
        .mem_rdata_valid(mem_rdata_valid), .mem_wack(mem_wack), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    mem_arbiter #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(t_req0_done),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(t_req1_done),
        .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
        .mem_cmd_valid(t_mem_cmd_valid), .mem_cmd_write(t_mem_cmd_write),
        .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_cmd_ready(mem_cmd_ready),
        .mem_rdata_valid(mem_rdata_valid), .mem_wack(mem_wack), .mem_rdata(mem_rdata),
        .grant(t_grant), .busy(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic        wr;
        logic [24:0] addr;
        logic [15:0] wdata;
        int          rdy_dly;
        int          rsp_dly;
        logic        noise;
        logic [15:0] rdata;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic p, input logic v, input logic w,
                           input logic [24:0] a, input logic [15:0] d);
        if (!p) begin
            req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_wack = 1'b0; mem_rdata = '0;
    endtask

    // Called while the DUT is in ISSUE: accept immediately, answer on the first WAIT cycle.
    task automatic complete_read(input logic exp_g, input logic [24:0] exp_a, input logic [15:0] rd);
        chk("arb_issue_valid", 32'(mem_cmd_valid), 32'd1);
        chk("arb_grant", 32'(grant), 32'(exp_g));
        chk("arb_addr", 32'(mem_addr), 32'(exp_a));
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        mem_rdata_valid = 1'b1;
        mem_rdata = rd;
        tick();
        mem_rdata_valid = 1'b0;
        chk("arb_done0", 32'(req0_done), 32'(!exp_g));
        chk("arb_done1", 32'(req1_done), 32'(exp_g));
        chk("arb_rdata", 32'(rsp_rdata), 32'(rd));
    endtask

    task automatic run_vec(input vec_t v);
        set_req(v.port, 1'b1, v.wr, v.addr, v.wdata);
        tick();
        for (int i = 0; i <= v.rdy_dly; i++) begin
            chk("vec_cmd_valid", 32'(mem_cmd_valid), 32'd1);
            chk("vec_cmd_write", 32'(mem_cmd_write), 32'(v.wr));
            chk("vec_addr", 32'(mem_addr), 32'(v.addr));
            chk("vec_wdata", 32'(mem_wdata), 32'(v.wdata));
            chk("vec_grant", 32'(grant), 32'(v.port));
            chk("vec_busy", 32'(busy), 32'd1);
            if (i == 0) begin
                set_req(v.port, 1'b1, ~v.wr, ~v.addr, ~v.wdata);
            end
            if (v.noise) begin
                mem_rdata_valid = !v.wr;
                mem_wack = v.wr;
                mem_rdata = 16'hDEAD;
            end
            mem_cmd_ready = (i == v.rdy_dly);
            tick();
        end
        mem_cmd_ready = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_wack = 1'b0;
        chk("vec_wait_cmd_valid", 32'(mem_cmd_valid), 32'd0);
        chk("vec_wait_addr", 32'(mem_addr), 32'(v.addr));
        for (int j = 0; j < v.rsp_dly; j++) begin
            if (v.noise) begin
                mem_rdata_valid = v.wr;
                mem_wack = !v.wr;
                mem_rdata = 16'hBEEF;
            end
            tick();
            mem_rdata_valid = 1'b0;
            mem_wack = 1'b0;
            chk("vec_wait_no_done", 32'({req1_done, req0_done}), 32'd0);
            chk("vec_wait_busy", 32'(busy), 32'd1);
        end
        mem_rdata_valid = !v.wr;
        mem_wack = v.wr;
        mem_rdata = v.rdata;
        tick();
        mem_rdata_valid = 1'b0;
        mem_wack = 1'b0;
        set_req(v.port, 1'b0, 1'b0, '0, '0);
        chk("vec_done0", 32'(req0_done), 32'(!v.port));
        chk("vec_done1", 32'(req1_done), 32'(v.port));
        chk("vec_err", 32'(rsp_err), 32'(v.exp_err));
        if (!v.wr) begin
            chk("vec_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
        end
        tick();
        chk("vec_idle_busy", 32'(busy), 32'd0);
        chk("vec_idle_done", 32'({req1_done, req0_done}), 32'd0);
        chk("vec_idle_cmd_valid", 32'(mem_cmd_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;

        tbl[0] = '{1'b0, 1'b0, 25'h1FFFFFF, 16'h0000, 0, 1, 1'b0, 16'hAAAA, 1'b0, 16'hAAAA};
        tbl[1] = '{1'b1, 1'b1, 25'h00000FF, 16'h5555, 3, 0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 25'h0123456, 16'hC0DE, 1, 2, 1'b1, 16'h0000, 1'b0, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 25'h1000000, 16'h0000, 0, 0, 1'b0, 16'h1234, 1'b0, 16'h1234};
        tbl[4] = '{1'b1, 1'b0, 25'h0ABCDEF, 16'h0000, 2, 3, 1'b1, 16'h8001, 1'b0, 16'h8001};

        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_cmd_valid", 32'(mem_cmd_valid), 32'd0);
        chk("rst_cmd_write", 32'(mem_cmd_write), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_done", 32'({req1_done, req0_done}), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Tie right after reset: port 0 first, then port 1 even though port 0 keeps asking.
        set_req(1'b0, 1'b1, 1'b0, 25'h0000010, 16'h0);
        set_req(1'b1, 1'b1, 1'b0, 25'h0000020, 16'h0);
        tick();
        complete_read(1'b0, 25'h0000010, 16'h0101);
        tick();
        chk("arb_gap_busy", 32'(busy), 32'd0);
        tick();
        complete_read(1'b1, 25'h0000020, 16'h0202);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        complete_read(1'b0, 25'h0000010, 16'h0303);
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("arb_end_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 5; k++) begin
            run_vec(tbl[k]);
        end

        // Reset while waiting for read data, then a stale response.
        set_req(1'b0, 1'b1, 1'b0, 25'h0000055, 16'h0);
        tick();
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        chk("rstw_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_done", 32'({req1_done, req0_done}), 32'd0);
        chk("rstw_cmd_valid", 32'(mem_cmd_valid), 32'd0);
        rst_n = 1'b1;
        mem_rdata_valid = 1'b1;
        mem_rdata = 16'hFFFF;
        tick();
        mem_rdata_valid = 1'b0;
        chk("late_done", 32'({req1_done, req0_done}), 32'd0);
        chk("late_busy", 32'(busy), 32'd0);
        chk("late_rdata", 32'(rsp_rdata), 32'd0);

        // TIMEOUT=4 instance: a good read first so the cleared read data is observable.
        set_req(1'b0, 1'b1, 1'b0, 25'h0000077, 16'h0);
        tick();
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        mem_rdata_valid = 1'b1;
        mem_rdata = 16'h7777;
        tick();
        mem_rdata_valid = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        chk("to_ok_done", 32'(t_req0_done), 32'd1);
        chk("to_ok_rdata", 32'(t_rsp_rdata), 32'h7777);
        chk("to_ok_err", 32'(t_rsp_err), 32'd0);
        tick();

        // Read accepted but never answered: done with error 4 cycles after ISSUE entry.
        set_req(1'b0, 1'b1, 1'b0, 25'h0000099, 16'h0);
        tick();
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        tick();
        tick();
        chk("to_wait_no_done", 32'({t_req1_done, t_req0_done}), 32'd0);
        chk("to_wait_busy", 32'(t_busy), 32'd1);
        tick();
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        chk("to_wait_done", 32'(t_req0_done), 32'd1);
        chk("to_wait_err", 32'(t_rsp_err), 32'd1);
        chk("to_wait_rdata", 32'(t_rsp_rdata), 32'd0);
        chk("to_wait_cmd_valid", 32'(t_mem_cmd_valid), 32'd0);
        tick();
        chk("to_wait_idle", 32'(t_busy), 32'd0);

        // Write never accepted: command held 4 cycles, then dropped with error.
        set_req(1'b1, 1'b1, 1'b1, 25'h00000AB, 16'h1357);
        tick();
        chk("to_iss_grant", 32'(t_grant), 32'd1);
        chk("to_iss_valid0", 32'(t_mem_cmd_valid), 32'd1);
        tick();
        tick();
        tick();
        chk("to_iss_valid3", 32'(t_mem_cmd_valid), 32'd1);
        chk("to_iss_no_done", 32'(t_req1_done), 32'd0);
        tick();
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        chk("to_iss_done", 32'(t_req1_done), 32'd1);
        chk("to_iss_err", 32'(t_rsp_err), 32'd1);
        chk("to_iss_cmd_drop", 32'(t_mem_cmd_valid), 32'd0);
        tick();
        chk("to_iss_idle", 32'(t_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 25, SHALL set memory address width in bits.
REQ-002 Parameter DATA_W, default 16, SHALL set memory data width in bits.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the max cycles from ISSUE entry to response before error; legal range 1..255.
REQ-004 clk  in  1  SHALL be the single clock; all logic rising-edge.
REQ-005 rst_n  in  1  SHALL be the synchronous, active-low reset.
REQ-006 req0_valid, req1_valid  in  1 each  SHALL be the request strobes; held high until the matching done.
REQ-007 req0_write, req1_write  in  1 each  SHALL select write (1) or read (0).
REQ-008 req0_addr, req1_addr  in  ADDR_W each  SHALL be the request addresses.
REQ-009 req0_wdata, req1_wdata  in  DATA_W each  SHALL be the write data.
REQ-010 req0_done, req1_done  out  1 each  SHALL be one-cycle completion pulses.
REQ-011 rsp_rdata  out  DATA_W  SHALL be read data, valid with a done pulse.
REQ-012 rsp_err  out  1  SHALL flag timeout, valid with a done pulse.
REQ-013 mem_cmd_valid, mem_cmd_write  out  1 each  SHALL be the command strobe and direction to memory.
REQ-014 mem_addr, mem_wdata  out  ADDR_W, DATA_W  SHALL be the latched command fields.
REQ-015 mem_cmd_ready  in  1  SHALL indicate memory accepted the command this cycle.
REQ-016 mem_rdata_valid, mem_wack  in  1 each  SHALL be read-data-valid and write-acknowledge.
REQ-017 mem_rdata  in  DATA_W  SHALL be the read data, sampled with mem_rdata_valid.
REQ-018 grant  out  1  SHALL identify the port owning the current transaction; busy  out  1  SHALL be high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: any reqN_valid high -> latch winner's write/addr/wdata, set grant, go ISSUE next cycle.
REQ-021 Arbitration: one valid wins; both valid -> port other than last_grant wins (round-robin).
REQ-022 ISSUE: mem_cmd_valid=1 with latched fields held stable; mem_cmd_ready=1 -> WAIT next cycle.
REQ-023 WAIT: read completes on mem_rdata_valid (register mem_rdata into rsp_rdata), write on mem_wack; -> DONE next cycle, rsp_err=0.
REQ-024 Timeout counter (8-bit) SHALL clear on ISSUE entry, increment each cycle in ISSUE/WAIT; reaching TIMEOUT -> DONE with rsp_err=1, mem_cmd_valid dropped, rsp_rdata=0.
REQ-025 DONE: exactly one cycle; pulse req{grant}_done; last_grant<=grant; -> IDLE.
REQ-026 Latency: request in IDLE at cycle 0, ready at cycle 1 -> WAIT cycle 2; response at cycle n -> done at n+1.
REQ-027 mem_rdata_valid/mem_wack SHALL be ignored outside WAIT; wrong-type response (wack on read) ignored.
REQ-028 Request-field changes after latching SHALL NOT affect mem_* outputs.
REQ-029 A requester keeping valid high after done SHALL be treated as a new request in the next IDLE, subject to REQ-021.
REQ-030 mem_cmd_valid SHALL be low in IDLE, WAIT, DONE.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE from any state, including mid-transaction, with no done pulse.
REQ-032 Reset values: mem_cmd_valid=0, mem_cmd_write=0, mem_addr=0, mem_wdata=0, req0_done=req1_done=0, rsp_rdata=0, rsp_err=0, grant=0, busy=0, counter=0, last_grant=1 (port 0 wins first tie).

Verification
REQ-033 Port0 read addr 0x1FFFFFF, ready same cycle, mem_rdata=0xAAAA two cycles later -> mem_addr=0x1FFFFFF, req0_done pulse, rsp_rdata=0xAAAA, rsp_err=0.
REQ-034 Both valid at once after reset -> port0 served first, then port1 without port0 re-winning while port1 waits.
REQ-035 Port1 write 0x5555 to 0x0000FF, ready held low 3 cycles -> mem_cmd_valid/fields stable 4 cycles; wack -> req1_done, rsp_err=0.
REQ-036 TIMEOUT=4, read with no response -> req0_done with rsp_err=1 exactly 4 cycles after ISSUE entry, then IDLE.
REQ-037 rst_n low during WAIT -> next cycle IDLE, busy=0, no done pulse; late mem_rdata_valid ignored.
